// File: rtl/tcc_pkg.sv
// Shared encodings for the accumulator-CPU control path: opcodes, FSM states,
// ALU operations and the opcode class record produced by the decoder.
package tcc_pkg;
    localparam int TCC_OPCODE_W = 5;
    localparam int TCC_DATA_W   = 11;

    typedef enum logic [4:0] {
        OP_HLT  = 5'd0,  OP_STO  = 5'd1,  OP_LD   = 5'd2,  OP_LDI  = 5'd3,
        OP_ADD  = 5'd4,  OP_ADDI = 5'd5,  OP_SUB  = 5'd6,  OP_SUBI = 5'd7,
        OP_BEQ  = 5'd8,  OP_BNE  = 5'd9,  OP_BLT  = 5'd10, OP_JMP  = 5'd11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_MEM_WAIT, ST_EXECUTE, ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS_B = 2'b00, ALU_ADD = 2'b01, ALU_SUB = 2'b10, ALU_RSVD = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_EQ, BR_NE, BR_LT, BR_ALWAYS
    } br_cond_e;

    typedef struct packed {
        logic     mem;
        logic     imm;
        logic     branch;
        logic     store;
        logic     halt;
        logic     illegal;
        alu_op_e  alu_op;
        br_cond_e br_cond;
    } op_class_t;

    function automatic logic br_taken(input br_cond_e cond, input logic zero, input logic neg);
        case (cond)
            BR_EQ:   return zero;
            BR_NE:   return !zero;
            BR_LT:   return neg;
            default: return 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: memory operand, immediate, branch, store,
// halt or undefined, plus the ALU operation and branch condition.
module opcode_decoder
    import tcc_pkg::*;
#(
    parameter int OPCODE_W = TCC_OPCODE_W
) (
    input  logic [OPCODE_W-1:0] opcode_in,
    output op_class_t           class_out
);
    logic [31:0] w_op;

    assign w_op = 32'(opcode_in);

    always_comb begin
        class_out = '0;
        case (w_op)
            32'(OP_HLT):  class_out.halt = 1'b1;
            32'(OP_STO):  class_out.store = 1'b1;
            32'(OP_LD):   class_out.mem = 1'b1;
            32'(OP_LDI):  class_out.imm = 1'b1;
            32'(OP_ADD):  begin class_out.mem = 1'b1; class_out.alu_op = ALU_ADD; end
            32'(OP_ADDI): begin class_out.imm = 1'b1; class_out.alu_op = ALU_ADD; end
            32'(OP_SUB):  begin class_out.mem = 1'b1; class_out.alu_op = ALU_SUB; end
            32'(OP_SUBI): begin class_out.imm = 1'b1; class_out.alu_op = ALU_SUB; end
            32'(OP_BEQ):  begin class_out.branch = 1'b1; class_out.br_cond = BR_EQ; end
            32'(OP_BNE):  begin class_out.branch = 1'b1; class_out.br_cond = BR_NE; end
            32'(OP_BLT):  begin class_out.branch = 1'b1; class_out.br_cond = BR_LT; end
            32'(OP_JMP):  begin class_out.branch = 1'b1; class_out.br_cond = BR_ALWAYS; end
            default:      class_out.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: FETCH -> DECODE -> [MEM_WAIT] -> EXECUTE, or HALT.
// Strobes are decoded from the current state and the IR opcode.
module control_unit
    import tcc_pkg::*;
#(
    parameter int OPCODE_W = TCC_OPCODE_W,
    parameter int DATA_W   = TCC_DATA_W
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [OPCODE_W-1:0] opcode_in,
    input  logic                zero_in,
    input  logic                neg_in,
    output logic                ir_load_out,
    output logic                pc_inc_out,
    output logic                pc_load_out,
    output logic                sel_B,
    output logic [1:0]          alu_op_out,
    output logic                acc_we_out,
    output logic                mem_rd_out,
    output logic                mem_we_out,
    output logic                halt_out,
    output logic                illegal_out
);
    if (OPCODE_W < 4 || OPCODE_W > 32 || DATA_W < 1) begin : g_param_check
        $error("control_unit: unsupported OPCODE_W/DATA_W");
    end

    state_e    r_state;
    logic      r_boot;
    op_class_t w_cls;

    opcode_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
        .opcode_in (opcode_in),
        .class_out (w_cls)
    );

    // r_boot holds a quiet cycle after reset so nothing strobes until the FSM restarts in FETCH.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_FETCH;
            r_boot  <= 1'b1;
        end else begin
            r_boot <= 1'b0;
            if (!r_boot) begin
                case (r_state)
                    ST_FETCH:    r_state <= ST_DECODE;
                    ST_DECODE: begin
                        if (w_cls.illegal)   r_state <= ST_FETCH;
                        else if (w_cls.halt) r_state <= ST_HALT;
                        else if (w_cls.mem)  r_state <= ST_MEM_WAIT;
                        else                 r_state <= ST_EXECUTE;
                    end
                    ST_MEM_WAIT: r_state <= ST_EXECUTE;
                    ST_EXECUTE:  r_state <= ST_FETCH;
                    ST_HALT:     r_state <= ST_HALT;
                    default:     r_state <= ST_FETCH;
                endcase
            end
        end
    end

    always_comb begin
        ir_load_out = 1'b0;
        pc_inc_out  = 1'b0;
        pc_load_out = 1'b0;
        sel_B       = 1'b0;
        alu_op_out  = ALU_PASS_B;
        acc_we_out  = 1'b0;
        mem_rd_out  = 1'b0;
        mem_we_out  = 1'b0;
        halt_out    = 1'b0;
        illegal_out = 1'b0;
        if (!r_boot) begin
            case (r_state)
                ST_FETCH: begin
                    ir_load_out = 1'b1;
                    pc_inc_out  = 1'b1;
                end
                ST_DECODE: begin
                    mem_rd_out  = w_cls.mem;
                    illegal_out = w_cls.illegal;
                end
                ST_MEM_WAIT: begin
                    mem_rd_out = 1'b1;
                    sel_B      = 1'b1;
                end
                ST_EXECUTE: begin
                    if (w_cls.mem || w_cls.imm) begin
                        acc_we_out = 1'b1;
                        sel_B      = w_cls.mem;
                        alu_op_out = w_cls.alu_op;
                    end
                    mem_we_out  = w_cls.store;
                    pc_load_out = w_cls.branch && br_taken(w_cls.br_cond, zero_in, neg_in);
                end
                ST_HALT:  halt_out = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: vector table, directed corner sequences and a
// randomized instruction stream checked against an instruction-level model.
module tb_control_unit;
    typedef struct packed {
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       sel_b;
        logic [1:0] alu_op;
        logic       acc_we;
        logic       mem_rd;
        logic       mem_we;
        logic       halt;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [4:0] op;
        bit         z;
        bit         n;
        int         len;
        outs_t      last;
        string      name;
    } vec_t;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [4:0] opcode_in;
    logic       zero_in, neg_in;
    logic       ir_load_out, pc_inc_out, pc_load_out, sel_B;
    logic [1:0] alu_op_out;
    logic       acc_we_out, mem_rd_out, mem_we_out, halt_out, illegal_out;
    outs_t      act;

    int n_checks = 0;
    int n_errors = 0;
    vec_t tbl[$];

    control_unit #(.OPCODE_W(5), .DATA_W(11)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .opcode_in   (opcode_in),
        .zero_in     (zero_in),
        .neg_in      (neg_in),
        .ir_load_out (ir_load_out),
        .pc_inc_out  (pc_inc_out),
        .pc_load_out (pc_load_out),
        .sel_B       (sel_B),
        .alu_op_out  (alu_op_out),
        .acc_we_out  (acc_we_out),
        .mem_rd_out  (mem_rd_out),
        .mem_we_out  (mem_we_out),
        .halt_out    (halt_out),
        .illegal_out (illegal_out)
    );

    always #5 clk_in = ~clk_in;

    assign act = {ir_load_out, pc_inc_out, pc_load_out, sel_B, alu_op_out,
                  acc_we_out, mem_rd_out, mem_we_out, halt_out, illegal_out};

    function automatic outs_t mk(bit ir, bit inc, bit pl, bit sb, bit [1:0] alu,
                                 bit acc, bit rd, bit we, bit h, bit ill);
        return outs_t'({ir, inc, pl, sb, alu, acc, rd, we, h, ill});
    endfunction

    localparam outs_t ZERO_V  = '0;
    localparam outs_t FETCH_V = 11'b110_0000_0000;
    localparam outs_t HALT_V  = 11'b000_0000_0010;

    // Instruction-level reference: cycle c of an instruction with opcode op.
    function automatic int ref_len(int op);
        if (op > 11 || op == 0) return 2;
        if (op == 2 || op == 4 || op == 6) return 4;
        return 3;
    endfunction

    function automatic outs_t ref_out(int op, int c, bit z, bit n);
        outs_t o = '0;
        bit mem = (op == 2 || op == 4 || op == 6);
        bit imm = (op == 3 || op == 5 || op == 7);
        if (c == 0) begin o.ir_load = 1'b1; o.pc_inc = 1'b1; return o; end
        if (op > 11) begin o.illegal = (c == 1); return o; end
        if (c == 1) begin o.mem_rd = mem; return o; end
        if (mem && c == 2) begin o.mem_rd = 1'b1; o.sel_b = 1'b1; return o; end
        if (mem || imm) begin
            o.acc_we = 1'b1;
            o.sel_b  = mem;
            o.alu_op = 2'((op - 2) / 2);
        end
        o.mem_we  = (op == 1);
        o.pc_load = (op == 11) || (op == 8 && z) || (op == 9 && !z) || (op == 10 && n);
        return o;
    endfunction

    task automatic tick_check(input outs_t exp, input string name);
        @(negedge clk_in);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: outputs got %h required %h (t=%0t)", name, act, exp, $time);
        end
        n_checks++;
        if ((act.pc_inc && act.pc_load) || (act.acc_we && act.mem_we)) begin
            n_errors++;
            $display("FAIL %s_exclusive: outputs got %h, required no conflicting strobes", name, act);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic add_vec(input int op, input bit z, input bit n, input int len,
                           input outs_t last, input string name);
        vec_t v;
        v.op = 5'(op); v.z = z; v.n = n; v.len = len; v.last = last; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        opcode_in = 5'($urandom_range(0, 31));
        tick_check(FETCH_V, {v.name, "_fetch"});
        opcode_in = v.op;
        zero_in   = v.z;
        neg_in    = v.n;
        for (int c = 1; c < v.len - 1; c++) begin
            @(posedge clk_in);
            #1;
        end
        tick_check(v.last, v.name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        add_vec(3,  0, 0, 3, mk(0,0,0,0,2'b00,1,0,0,0,0), "ldi");
        add_vec(4,  0, 0, 4, mk(0,0,0,1,2'b01,1,0,0,0,0), "add");
        add_vec(5,  1, 1, 3, mk(0,0,0,0,2'b01,1,0,0,0,0), "addi");
        add_vec(6,  0, 1, 4, mk(0,0,0,1,2'b10,1,0,0,0,0), "sub");
        add_vec(7,  1, 0, 3, mk(0,0,0,0,2'b10,1,0,0,0,0), "subi");
        add_vec(2,  0, 0, 4, mk(0,0,0,1,2'b00,1,0,0,0,0), "ld");
        add_vec(1,  0, 0, 3, mk(0,0,0,0,2'b00,0,0,1,0,0), "sto");
        add_vec(8,  1, 0, 3, mk(0,0,1,0,2'b00,0,0,0,0,0), "beq_taken");
        add_vec(8,  0, 1, 3, ZERO_V,                      "beq_not");
        add_vec(9,  0, 0, 3, mk(0,0,1,0,2'b00,0,0,0,0,0), "bne_taken");
        add_vec(9,  1, 0, 3, ZERO_V,                      "bne_not");
        add_vec(10, 1, 1, 3, mk(0,0,1,0,2'b00,0,0,0,0,0), "blt_taken");
        add_vec(10, 1, 0, 3, ZERO_V,                      "blt_not");
        add_vec(11, 0, 0, 3, mk(0,0,1,0,2'b00,0,0,0,0,0), "jmp");
        add_vec(20, 0, 0, 2, mk(0,0,0,0,2'b00,0,0,0,0,1), "illegal20");
        add_vec(31, 1, 1, 2, mk(0,0,0,0,2'b00,0,0,0,0,1), "illegal31");
        add_vec(12, 0, 0, 2, mk(0,0,0,0,2'b00,0,0,0,0,1), "illegal12");

        rst_in = 1'b1; opcode_in = '0; zero_in = 1'b0; neg_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        tick_check(ZERO_V, "reset_outputs");

        foreach (tbl[i]) run_vec(tbl[i]);

        // LDI then ADD then STO, every cycle checked
        tick_check(FETCH_V, "seq_ldi_fetch");
        opcode_in = 5'd3;
        tick_check(ZERO_V, "seq_ldi_decode");
        tick_check(mk(0,0,0,0,2'b00,1,0,0,0,0), "seq_ldi_exec");
        tick_check(FETCH_V, "seq_add_fetch");
        opcode_in = 5'd4;
        tick_check(mk(0,0,0,0,2'b00,0,1,0,0,0), "seq_add_decode");
        tick_check(mk(0,0,0,1,2'b00,0,1,0,0,0), "seq_add_memwait");
        tick_check(mk(0,0,0,1,2'b01,1,0,0,0,0), "seq_add_exec");
        tick_check(FETCH_V, "seq_sto_fetch");
        opcode_in = 5'd1;
        tick_check(ZERO_V, "seq_sto_decode");
        tick_check(mk(0,0,0,0,2'b00,0,0,1,0,0), "seq_sto_exec");
        tick_check(FETCH_V, "seq_sto_next_fetch");
        opcode_in = 5'd20;
        tick_check(mk(0,0,0,0,2'b00,0,0,0,0,1), "seq_ill_decode");

        // randomized instruction stream against the reference model
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) op = int'($urandom_range(12, 31));
            else                           op = int'($urandom_range(1, 11));
            for (int c = 0; c < ref_len(op); c++) begin
                zero_in   = 1'($urandom);
                neg_in    = 1'($urandom);
                opcode_in = (c == 0) ? 5'($urandom_range(0, 31)) : 5'(op);
                tick_check(ref_out(op, c, zero_in, neg_in), "random");
            end
        end

        // reset in the middle of an LD's MEM_WAIT
        opcode_in = 5'd9;
        tick_check(FETCH_V, "rstld_fetch");
        opcode_in = 5'd2;
        tick_check(mk(0,0,0,0,2'b00,0,1,0,0,0), "rstld_decode");
        rst_in = 1'b1;
        tick_check(mk(0,0,0,1,2'b00,0,1,0,0,0), "rstld_memwait");
        rst_in = 1'b0;
        tick_check(ZERO_V, "rstld_after_reset");
        tick_check(FETCH_V, "rstld_refetch");

        // HLT is absorbing until reset
        opcode_in = 5'd0;
        tick_check(ZERO_V, "hlt_decode");
        for (int k = 0; k < 12; k++) begin
            opcode_in = 5'($urandom_range(0, 31));
            zero_in   = 1'($urandom);
            neg_in    = 1'($urandom);
            tick_check(HALT_V, "halt_hold");
        end
        rst_in = 1'b1;
        tick_check(HALT_V, "halt_during_reset");
        rst_in = 1'b0;
        tick_check(ZERO_V, "halt_after_reset");
        tick_check(FETCH_V, "halt_refetch");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
